// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that sequences writes from
// NUM_REQ requesters into one shared DATA_W-bit register with a tenure cap.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset_n      - synchronous active-low reset
//   req          - per-requester request / write enable (level)
//   wdata        - write data, lane i = wdata[i*DATA_W +: DATA_W]
//   grant        - one-hot current owner, all-zero when idle
//   owner        - binary index of current owner, 0 when idle
//   busy         - high while a grant is held
//   q            - shared register contents
//   q_valid      - one-cycle pulse: q was written at the preceding edge
//   grant_count  - (SHARED_REG_STATS_EN only) 16-bit saturating
//                  grant counter per requester, lane i = [i*16 +: 16]
//
// Build option: define SHARED_REG_STATS_EN to add grant_count.

module shared_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [2:0]                owner,
    output logic                      busy,
    output logic [DATA_W-1:0]         q,
    output logic                      q_valid
`ifdef SHARED_REG_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_count
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;

    logic              new_grant;
    logic [3:0]        pick;
    logic [2:0]        next_ptr;
    logic              do_write;
    logic              release_now;
    logic [IW-1:0]     owner_idx;

    logic [DATA_W-1:0] lane [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = wdata[g*DATA_W +: DATA_W];
    end

    // First set bit of r at or after start, wrapping; {hit, index}.
    // Starting one past the old owner naturally checks it last.
    function automatic logic [3:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [2:0]         start
    );
        logic       hit;
        logic [2:0] idx;
        int         c;
        hit = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(start) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!hit && r[c[IW-1:0]]) begin
                hit = 1'b1;
                idx = 3'(c);
            end
        end
        return {hit, idx};
    endfunction

    assign owner_idx = owner_q[IW-1:0];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        q_d         = q_q;
        q_valid_d   = 1'b0;
        new_grant   = 1'b0;
        pick        = 4'd0;
        do_write    = 1'b0;
        release_now = 1'b0;
        next_ptr    = 3'd0;

        unique case (state_q)
            S_IDLE: begin
                pick = rr_pick(req, rr_ptr_q);
                if (pick[3]) begin
                    state_d    = S_GRANT;
                    owner_d    = pick[2:0];
                    hold_cnt_d = '0;
                    new_grant  = 1'b1;
                end
            end
            S_GRANT: begin
                do_write = req[owner_idx];
                if (do_write) begin
                    q_d        = lane[owner_idx];
                    q_valid_d  = 1'b1;
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
                // Drop of request, or the write that completes the tenure.
                release_now = !do_write ||
                              (hold_cnt_q == HW'(MAX_HOLD - 1));
                if (release_now) begin
                    if (owner_q == 3'(NUM_REQ - 1)) begin
                        next_ptr = 3'd0;
                    end else begin
                        next_ptr = owner_q + 3'd1;
                    end
                    rr_ptr_d   = next_ptr;
                    hold_cnt_d = '0;
                    pick       = rr_pick(req, next_ptr);
                    if (pick[3]) begin
                        // Hand over with no idle gap (may re-grant self).
                        owner_d   = pick[2:0];
                        new_grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        owner_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 3'd0;
            rr_ptr_q   <= 3'd0;
            hold_cnt_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = (state_q == S_GRANT) && (owner_q == 3'(i));
        end
    end

    assign owner   = owner_q;
    assign busy    = (state_q == S_GRANT);
    assign q       = q_q;
    assign q_valid = q_valid_q;

`ifdef SHARED_REG_STATS_EN
    logic [15:0] gcnt_q [NUM_REQ];
    logic [15:0] gcnt_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (new_grant && (owner_d == 3'(i)) &&
                (gcnt_q[i] != 16'hFFFF)) begin
                gcnt_d[i] = gcnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset_n) begin
                gcnt_q[i] <= 16'd0;
            end else begin
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_count[g*16 +: 16] = gcnt_q[g];
    end
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed scenarios plus random traffic checked
// against a behavioural model of the shared register arbiter.

module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [2:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic           q_valid;
`ifdef SHARED_REG_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    shared_reg_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .MAX_HOLD(MH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .wdata      (wdata),
        .grant      (grant),
        .owner      (owner),
        .busy       (busy),
        .q          (q),
        .q_valid    (q_valid)
`ifdef SHARED_REG_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner index (-1 idle), tenure writes, pointer, register, counts.
    int         m_own;
    int         m_ptr;
    int         m_writes;
    logic [W-1:0] m_q;
    logic       m_qv;
    int         m_cnt [N];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_search(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    task automatic m_award(input int who);
        m_own    = who;
        m_writes = 0;
        if (who >= 0 && m_cnt[who] < 65535) m_cnt[who]++;
    endtask

    task automatic m_step();
        bit rel;
        if (!reset_n) begin
            m_own = -1; m_ptr = 0; m_writes = 0;
            m_q = '0; m_qv = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_own < 0) begin
            m_qv = 1'b0;
            m_award(m_search(req, m_ptr));
        end else begin
            rel = 1'b1;
            m_qv = 1'b0;
            if (req[m_own]) begin
                m_q = wdata[m_own*W +: W];
                m_qv = 1'b1;
                m_writes++;
                rel = (m_writes == MH);
            end
            if (rel) begin
                m_ptr = (m_own + 1) % N;
                m_award(m_search(req, m_ptr));
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        check("grant", 32'(grant), 32'(eg));
        check("owner", 32'(owner), (m_own < 0) ? 32'd0 : 32'(m_own));
        check("busy", 32'(busy), 32'(m_own >= 0));
        check("q", 32'(q), 32'(m_q));
        check("q_valid", 32'(q_valid), 32'(m_qv));
`ifdef SHARED_REG_STATS_EN
        for (int i = 0; i < N; i++) begin
            check("grant_count", 32'(grant_count[i*16 +: 16]),
                  32'(m_cnt[i]));
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        wdata   = 32'h13121110;
        m_own = -1; m_ptr = 0; m_writes = 0; m_q = '0; m_qv = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset with all requesting, then first grant from pointer 0.
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        reset_n = 1'b1;
        tick();
        check("first_grant", 32'(grant), 32'b0001);

        // Single requester on lane 2.
        do_reset();
        req   = 4'b0100;
        wdata = 32'h00A50000;
        tick();
        check("single_grant", 32'(grant), 32'b0100);
        tick();
        check("single_q", 32'(q), 32'hA5);
        check("single_qv", 32'(q_valid), 32'd1);
        tick();
        req = '0;
        tick();
        check("single_rel_grant", 32'(grant), 32'd0);
        check("single_rel_busy", 32'(busy), 32'd0);

        // Round-robin among 0, 1, 3 with full tenures.
        do_reset();
        req   = 4'b1011;
        wdata = 32'h13121110;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 1)  check("rr_own_a", 32'(owner), 32'd0);
            if (t == 5)  check("rr_own_b", 32'(owner), 32'd1);
            if (t == 9)  check("rr_own_c", 32'(owner), 32'd3);
            if (t == 13) check("rr_own_d", 32'(owner), 32'd0);
            if (t >= 2)  check("rr_qv", 32'(q_valid), 32'd1);
        end

        // Sole requester keeps being re-granted.
        do_reset();
        req = 4'b0010;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("sole_grant", 32'(grant), 32'b0010);
            if (t >= 2) check("sole_qv", 32'(q_valid), 32'd1);
        end

        // Reset lands on owner 3's second write.
        do_reset();
        req   = 4'b1000;
        wdata = 32'h33000000;
        tick();
        tick();
        check("midrst_q1", 32'(q), 32'h33);
        wdata   = 32'hFF000000;
        reset_n = 1'b0;
        tick();
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        reset_n = 1'b1;
        req     = '0;
        tick();
        check("midrst_q_after", 32'(q), 32'd0);

        // Owner 0 drops while 2 is pending.
        do_reset();
        req   = 4'b0001;
        wdata = 32'h00520050;
        tick();
        req = 4'b0101;
        tick();
        req = 4'b0100;
        tick();
        check("hand_grant", 32'(grant), 32'b0100);
        check("hand_qv", 32'(q_valid), 32'd0);
        tick();
        check("hand_q", 32'(q), 32'h52);
        check("hand_qv2", 32'(q_valid), 32'd1);

        // Random traffic.
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            wdata   = $urandom;
            reset_n = ($urandom_range(0, 39) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares a single DATA_W-bit D-flip-flop register among NUM_REQ requesters. It grants one requester at a time and captures that requester's write data into the shared register. It enforces a maximum tenure per grant so that no requester can starve the others. It sits between the requester blocks and the storage flip-flop bank and sequences every write to that bank.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, width of the shared register and of each write-data lane
MAX_HOLD, 4, maximum consecutive write cycles per grant (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
req  input  NUM_REQ  request/write-enable per requester, level
wdata  input  NUM_REQ*DATA_W  write data; lane i = wdata[i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot current owner, registered; all-zero when idle
owner  output  3  binary index of current owner; 0 when idle
busy  output  1  1 while in GRANT state
q  output  DATA_W  shared register contents
q_valid  output  1  1-cycle pulse: q was written at the preceding edge

Behaviour:
- Reset state: the following apply on any clk edge with reset_n=0.
  - grant=0, owner=0, busy=0, q=0, q_valid=0.
  - Round-robin pointer rr_ptr=0 and hold_cnt=0.
  - State = IDLE.
  - Reset asserted mid-tenure aborts the grant immediately; no write occurs on that edge.
- FSM states: IDLE, GRANT.
- IDLE transition:
  - If req!=0 at an edge, select the first set bit searching from rr_ptr upward with wrap.
  - Set grant[sel]=1 and owner=sel, set hold_cnt=0, go to GRANT.
  - No write occurs on this edge.
- GRANT, write rule:
  - At each edge where req[owner]=1: q<=wdata lane owner, q_valid<=1, hold_cnt<=hold_cnt+1.
  - Otherwise q_valid<=0 and q holds its value.
- GRANT, release condition: release occurs at an edge where req[owner]=0, or where a write occurs with hold_cnt==MAX_HOLD-1.
  - That final write, if any, still takes effect.
- On release:
  - Set rr_ptr=(owner+1) mod NUM_REQ.
  - Search req sampled at the same edge, starting from rr_ptr with wrap, with the old owner checked last.
  - If a hit is found: grant the hit directly in the next cycle with no idle gap, and set hold_cnt=0.
  - If no hit is found: go to IDLE with grant=0.
- Timing:
  - A sole requester that hits MAX_HOLD is re-granted immediately. Writes continue, but grant is re-issued and hold_cnt restarts.
  - Latency: req rises before edge k, so grant is high after edge k. The first write happens at edge k+1, and q/q_valid are visible after edge k+1.
- Requests from non-owners never write q. Exactly one grant bit is set in GRANT.
- wdata lanes of non-owners are ignored. X on those lanes must not propagate.
- The register holds its value indefinitely while IDLE.

Optional Feature:
SHARED_REG_STATS_EN
- Defined:
  - Adds output grant_count (NUM_REQ*16 bits), one 16-bit counter per requester.
  - A counter increments on each new grant issued to that requester, including immediate re-grants.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the port and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles while req=4'b1111 -> grant=0, busy=0, q=0, q_valid=0. After release, the first grant is grant=4'b0001 (rr_ptr=0).
- Single requester:
  - Stimulus: req=4'b0100, wdata lane2=8'hA5 for 2 cycles, then drop.
  - Response: grant=4'b0100 one edge later, q=8'hA5 with q_valid pulse. The edge after req drops gives grant=0 and busy=0.
- Round-robin:
  - Stimulus: req=4'b1011 held constant, MAX_HOLD=4, lanes 0/1/3 = 8'h10/8'h11/8'h13.
  - Response: owners cycle 0,1,3,0. Each tenure is exactly 4 writes, with no idle cycle between tenures.
- Tenure limit with sole requester:
  - Stimulus: req=4'b0010 for 10 cycles.
  - Response: grant stays 4'b0010 throughout and q_valid stays high after the first write.
  - With SHARED_REG_STATS_EN defined, grant_count[1] increments at writes 4 and 8.
- Mid-tenure reset:
  - Stimulus: assert reset_n=0 during the 2nd write of owner 3 with wdata=8'hFF.
  - Response: q=0 and grant=0 after that edge, and 8'hFF never appears on q.
- Handover on drop:
  - Stimulus: owner 0 drops req while req[2] has been pending.
  - Response: grant moves directly to 4'b0100 on the same release edge. The first lane-2 write lands on the following edge.
